// File: rtl/counter_pkg.sv
// Shared types and helpers for the up/down counter.
package counter_pkg;

  typedef enum logic {
    MODE_WRAP,
    MODE_SAT
  } count_mode_e;

  // Limit a value to the top of the legal count range.
  function automatic logic [31:0] clamp_val(input logic [31:0] v, input logic [31:0] max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/counter_updown_if.sv
// Control and status bundle of the up/down counter.
interface counter_updown_if #(
  parameter int unsigned WIDTH = 6
) ();
  import counter_pkg::*;

  logic             a;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] loadValue;
  logic [WIDTH-1:0] initValue;
  logic             clrOvf;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             atMax;
  logic             atZero;

  modport master (
    output a, up, load, loadValue, initValue, clrOvf,
    input  count, tc, ovf, atMax, atZero
  );

  modport slave (
    input  a, up, load, loadValue, initValue, clrOvf,
    output count, tc, ovf, atMax, atZero
  );

endinterface

// File: rtl/rise_detect.sv
// Single-cycle rising-edge detector for the count request.
module rise_detect
  import counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // History keeps tracking during reset, so a level held through reset is no edge.
  always_ff @(posedge clk) begin
    d_q <= d;
  end

  assign rise = d & ~d_q & ~rst;

endmodule

// File: rtl/counter_updown.sv
// Parametrised up/down event counter with programmable modulus, wrap or
// saturate bounds, level or edge counting, runtime load and boundary flags.
module counter_updown
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 6,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter bit          SATURATE  = 1'b0,
  parameter bit          EDGE_MODE = 1'b0
) (
  input logic            clk,
  input logic            rst,
  counter_updown_if.slave bus
);

  localparam count_mode_e      Mode   = SATURATE ? MODE_SAT : MODE_WRAP;
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

  if (WIDTH < 2 || MAX_COUNT < 1 || 64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_cfg
    $fatal(1, "counter_updown: MAX_COUNT must lie in 1 .. 2**WIDTH-1 and WIDTH >= 2");
  end

  logic             step;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  if (EDGE_MODE) begin : g_edge
    rise_detect u_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.a),
      .rise (step)
    );
  end else begin : g_level
    assign step = bus.a;
  end

  // Next count and flags; bounds are checked explicitly, never by natural wrap.
  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (bus.load) begin
      count_d = WIDTH'(clamp_val(32'(bus.loadValue), MAX_COUNT));
    end else if (step) begin
      if (bus.up) begin
        if (count_q >= MaxVal) begin
          boundary = 1'b1;
          count_d  = (Mode == MODE_SAT) ? MaxVal : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = (Mode == MODE_SAT) ? '0 : MaxVal;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    tc_d  = boundary;
    // A boundary event beats a simultaneous clear.
    ovf_d = boundary | (ovf_q & ~bus.clrOvf);
  end

  // State registers with synchronous reset to the clamped initial value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= WIDTH'(clamp_val(32'(bus.initValue), MAX_COUNT));
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count  = count_q;
  assign bus.tc     = tc_q;
  assign bus.ovf    = ovf_q;
  assign bus.atMax  = (count_q == MaxVal);
  assign bus.atZero = (count_q == '0);

endmodule
